// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared width default and count type for the binary counter
package counter_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 4;

    typedef logic [COUNTER_WIDTH_DEFAULT-1:0] count_t;

endpackage : counter_pkg

// File: rtl/incrementer.sv
// rtl/incrementer.sv - WIDTH-bit combinational +1, wrapping by truncation
module incrementer #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Sum is kept at WIDTH bits, so all-ones rolls over to zero with no carry-out.
    always_comb begin
        y = a + WIDTH'(1);
    end

endmodule : incrementer

// File: rtl/binary_counter.sv
// rtl/binary_counter.sv - free-running up-counter with synchronous active-high clear
module binary_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Q
);

    // Power-up value of zero lets the counter run before any reset is seen.
    logic [WIDTH-1:0] count = '0;
    logic [WIDTH-1:0] count_next;

    incrementer #(
        .WIDTH (WIDTH)
    ) u_incrementer (
        .a (count),
        .y (count_next)
    );

    // Clear has priority over the unconditional increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Output comes straight from the register; no input-to-output path.
    always_comb begin
        Q = count;
    end

endmodule : binary_counter

// File: tb/tb_binary_counter.sv
// tb/tb_binary_counter.sv - self-checking bench for binary_counter
module tb_binary_counter;
    import counter_pkg::*;

    localparam int W   = COUNTER_WIDTH_DEFAULT;
    localparam int MOD = 1 << W;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    count_t Q;

    int total  = 0;
    int passed = 0;
    int exp_q  = 0;

    binary_counter #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Q     (Q)
    );

    always #50 clk = ~clk;

    // Reference: the count the spec predicts, advanced once per rising edge.
    always @(posedge clk) begin
        if (reset === 1'b1)
            exp_q = 0;
        else
            exp_q = (exp_q + 1) % MOD;
    end

    task automatic check(input string tag, input count_t obs, input int expv);
        count_t e;
        e = count_t'(expv);
        total++;
        assert (obs === e) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    endtask

    task automatic wait_until(input int t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        // Power-up without reset.
        #1;
        check("powerup", Q, 0);

        // Free-running count through the first ten edges.
        for (int k = 1; k <= 10; k++) begin
            wait_until(k * 100);
            check("run_model", Q, exp_q);
            check("run_seq", Q, k);
        end
        check("ten_edges", Q, 4'hA);

        // First synchronous clear covering the edge at 1050.
        wait_until(1000);
        reset = 1'b1;
        #1;
        check("not_async", Q, 4'hA);
        wait_until(1100);
        check("clear1", Q, 0);
        reset = 1'b0;
        wait_until(1200);
        check("after_clear1", Q, 1);

        // Run through a wrap: 15 at 2600, 0 at 2700, 1 at 2800.
        wait_until(2600);
        check("pre_wrap", Q, 4'hF);
        wait_until(2700);
        check("wrap", Q, 0);
        wait_until(2800);
        check("post_wrap", Q, 1);

        // Second clear while non-zero.
        wait_until(6100);
        check("pre_clear2", Q, 2);
        reset = 1'b1;
        wait_until(6200);
        check("clear2", Q, 0);
        reset = 1'b0;
        wait_until(6300);
        check("resume1", Q, 1);
        wait_until(6400);
        check("resume2", Q, 2);

        // Held reset across five edges.
        wait_until(6500);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_until(6500 + k * 100);
            check("held", Q, 0);
        end
        reset = 1'b0;
        wait_until(7100);
        check("held_release", Q, 1);

        // Glitch entirely between edges is ignored.
        wait_until(7120);
        reset = 1'b1;
        wait_until(7140);
        reset = 1'b0;
        wait_until(7200);
        check("glitch", Q, 2);
        check("glitch_model", Q, exp_q);

        // Randomized clears and sub-edge glitches against the model.
        for (int c = 0; c < 300; c++) begin
            int base;
            base = 7200 + c * 100;
            if ($urandom_range(0, 3) == 0) begin
                wait_until(base + 5 + $urandom_range(0, 10));
                reset = 1'b1;
                wait_until(base + 30 + $urandom_range(0, 10));
                reset = 1'b0;
            end
            wait_until(base + 45);
            reset = ($urandom_range(0, 5) == 0);
            wait_until(base + 100);
            check("random", Q, exp_q);
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_binary_counter
